fetch_unit: RTL

Decoupled instruction-fetch stage feeding the FETCH→DECODE boundary of the 3-stage core. It replaces the bare PC register + combinational imem lookup with a request/grant/response instruction-memory port, a small in-order prefetch queue and branch-redirect handling. Its outputs (`inst_o`, `pc_o`, `inst_valid_o`) drive the FD instruction/PC buffers. `redirect_i` is driven by the execute-stage branch decision.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the instruction fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO with synchronous flush, used for fetched entries and in-flight PCs
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2,
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output T              o_head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_push = i_push & (r_count != CW'(DEPTH));
  assign w_pop  = i_pop & (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= next_ptr(r_wr);
      if (w_pop)  r_rd <= next_ptr(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled fetch stage: credit-based imem requests, prefetch queue, redirect flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  stall_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop_cnt;

  logic [CW-1:0]         w_occ;
  logic [CW-1:0]         w_pcq_count;
  logic [CW:0]           w_used;
  logic [CW:0]           w_limit;
  logic [ADDR_WIDTH-1:0] w_resp_pc;
  logic [ADDR_WIDTH-1:0] w_target;
  entry_t                w_head;
  logic                  w_pop;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_resp;
  logic                  w_accept;

  assign inst_valid_o = (w_occ != '0);
  assign w_pop    = inst_valid_o & ~stall_i & ~redirect_i;
  // credit > 0  <=>  occupancy + outstanding < DEPTH + pop
  assign w_used   = {1'b0, w_occ} + {1'b0, r_outstanding};
  assign w_limit  = (CW + 1)'(DEPTH) + (CW + 1)'(w_pop);
  assign w_req    = (w_used < w_limit) & ~redirect_i & ~reset;
  assign w_grant  = w_req & imem_gnt_i;
  assign w_resp   = imem_rvalid_i & (r_outstanding != '0);
  assign w_accept = w_resp & (r_drop_cnt == '0) & ~redirect_i;
  assign w_target = redirect_pc_i & ~ADDR_WIDTH'(3);

  fetch_queue #(.T(entry_t), .DEPTH(DEPTH)) u_inst_q (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_accept),
    .i_data  ({w_resp_pc, imem_rdata_i}),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_count (w_occ),
    .o_head  (w_head)
  );

  // Dropped stale responses must not consume PCs of post-redirect requests.
  fetch_queue #(.T(logic [ADDR_WIDTH-1:0]), .DEPTH(DEPTH)) u_pc_q (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_grant),
    .i_data  (r_fetch_pc),
    .i_pop   (w_resp & (r_drop_cnt == '0)),
    .i_flush (redirect_i),
    .o_count (w_pcq_count),
    .o_head  (w_resp_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_resp);
      if (redirect_i) begin
        r_fetch_pc <= w_target;
        r_drop_cnt <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
        if (w_resp && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign inst_o      = inst_valid_o ? w_head.inst : DATA_WIDTH'(NOP_INST);
  assign pc_o        = inst_valid_o ? w_head.pc : '0;

  always @(posedge clk) begin
    if (!reset) begin
      assert (r_outstanding <= CW'(DEPTH));
      assert (w_used <= (CW + 1)'(DEPTH));
      assert (!(imem_rvalid_i && r_outstanding == '0));
      assert (w_pcq_count <= r_outstanding);
    end
  end
endmodule
